// File: rtl/fire_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : fire_capture
//  Purpose  : Captures a pre/post-trigger window of ADC sample sets
//             {ad_b1, ad_b0, ad_a1, ad_a0} around a fire event into a circular
//             RAM, then streams the frame out over a valid/ready interface.
//  Ports    : clk, reset        - clock, synchronous active-high reset
//             ad_strobe, ad_*   - ADC monitor bus (one sample set per strobe)
//             arm, trig, abort  - capture control pulses
//             out_valid/ready/data/last - frame output stream
//             busy, frame_ready, frame_len - status
//  Revision : 1.0 - initial release
// ============================================================================
module fire_capture #(
  parameter int DEPTH     = 1024,
  parameter int PRE_TRIG  = 128,
  parameter int POST_TRIG = 768,
  parameter int DECIM     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ad_strobe,
  input  logic [11:0] ad_a0,
  input  logic [11:0] ad_a1,
  input  logic [11:0] ad_b0,
  input  logic [11:0] ad_b1,
  input  logic        arm,
  input  logic        trig,
  input  logic        abort,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [47:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        frame_ready,
  output logic [10:0] frame_len
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [10:0] PRE_L    = 11'(PRE_TRIG);
  localparam logic [10:0] POST_L   = 11'(POST_TRIG);
  localparam logic [7:0]  DEC_LAST = 8'(DECIM - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_POST = 3'd2,
    S_DONE = 3'd3,
    S_READ = 3'd4
  } state_t;

  state_t state, state_nx;

  logic [47:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, start_ptr;
  logic [7:0]    dec_cnt;
  logic [10:0]   pre_cnt, pre_len, post_cnt, rd_cnt;
  logic [47:0]   ram_q, skid_data;
  logic          rd_pend, pend_last, skid_valid, skid_last;
  logic          capturing, kept, pop, rd_issue;
  logic [1:0]    occ;

  assign capturing   = (state == S_PRE) || (state == S_POST);
  assign kept        = capturing && ad_strobe && (dec_cnt == 8'd0) && !abort;
  assign pop         = out_valid && out_ready;
  assign busy        = (state != S_IDLE);
  assign frame_ready = (state == S_DONE);

  // Words held or in flight: output register, skid register, pending RAM read.
  // A new read is issued only if its data is guaranteed a slot when it lands,
  // which still allows one read per cycle while the consumer keeps up.
  assign occ      = 2'(out_valid) + 2'(skid_valid) + 2'(rd_pend);
  assign rd_issue = (state == S_READ) && !abort && (rd_cnt != frame_len) &&
                    ((occ - 2'(pop)) < 2'd2);

  // --------------------------------------------------------------------------
  // State machine
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (arm) state_nx = S_PRE;
      S_PRE: begin
        if (trig) begin
          // A strobe kept in the trigger cycle is already post sample 0.
          if (kept && (POST_L == 11'd1)) state_nx = S_DONE;
          else                           state_nx = S_POST;
        end
      end
      S_POST: if (kept && (post_cnt == POST_L - 11'd1)) state_nx = S_DONE;
      S_DONE: if (out_ready || !out_valid) state_nx = S_READ;
      S_READ: if (pop && out_last) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (abort) state_nx = S_IDLE;
  end

  // --------------------------------------------------------------------------
  // Capture datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      start_ptr <= '0;
      dec_cnt   <= 8'd0;
      pre_cnt   <= 11'd0;
      pre_len   <= 11'd0;
      post_cnt  <= 11'd0;
      frame_len <= 11'd0;
    end else if (!abort) begin
      if ((state == S_IDLE) && arm) begin
        pre_cnt <= 11'd0;
        dec_cnt <= 8'd0;
      end
      if (capturing && ad_strobe)
        dec_cnt <= (dec_cnt == DEC_LAST) ? 8'd0 : dec_cnt + 8'd1;
      if (kept)
        wr_ptr <= wr_ptr + 1'b1;
      case (state)
        S_PRE: begin
          if (trig) begin
            pre_len   <= pre_cnt;
            start_ptr <= wr_ptr - AW'(pre_cnt);
            post_cnt  <= kept ? 11'd1 : 11'd0;
            if (kept && (POST_L == 11'd1))
              frame_len <= pre_cnt + POST_L;
          end else if (kept && (pre_cnt != PRE_L)) begin
            pre_cnt <= pre_cnt + 11'd1;
          end
        end
        S_POST: begin
          if (kept) begin
            post_cnt <= post_cnt + 11'd1;
            if (post_cnt == POST_L - 11'd1)
              frame_len <= pre_len + POST_L;
          end
        end
        default: ;
      endcase
    end
  end

  // Sample RAM: one write port, one registered read port.
  always_ff @(posedge clk) begin
    if (kept)
      mem[wr_ptr] <= {ad_b1, ad_b0, ad_a1, ad_a0};
    if (rd_issue)
      ram_q <= mem[rd_ptr];
  end

  // --------------------------------------------------------------------------
  // Read address generation
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr    <= '0;
      rd_cnt    <= 11'd0;
      rd_pend   <= 1'b0;
      pend_last <= 1'b0;
    end else begin
      rd_pend <= rd_issue;
      if (state == S_DONE) begin
        rd_ptr <= start_ptr;
        rd_cnt <= 11'd0;
      end
      if (rd_issue) begin
        rd_ptr    <= rd_ptr + 1'b1;
        rd_cnt    <= rd_cnt + 11'd1;
        pend_last <= (rd_cnt == frame_len - 11'd1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output register plus skid register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_data   <= 48'd0;
      skid_valid <= 1'b0;
      skid_last  <= 1'b0;
      skid_data  <= 48'd0;
    end else if (abort) begin
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      skid_valid <= 1'b0;
    end else if (pop || !out_valid) begin
      // Output slot is free: refill from skid first (older word), else RAM.
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        out_last   <= skid_last;
        skid_valid <= rd_pend;
        skid_data  <= ram_q;
        skid_last  <= pend_last;
      end else if (rd_pend) begin
        out_valid <= 1'b1;
        out_data  <= ram_q;
        out_last  <= pend_last;
      end else begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end else if (rd_pend) begin
      // Stalled: park the arriving word so the output stays stable.
      skid_valid <= 1'b1;
      skid_data  <= ram_q;
      skid_last  <= pend_last;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fire_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_fire_capture
//  Purpose  : Directed self-checking bench for fire_capture. Two instances
//             (DECIM=1 and DECIM=4, DEPTH=16, PRE_TRIG=4, POST_TRIG=6) share
//             clock, reset, ADC bus and out_ready; control pulses are separate.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fire_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        ad_strobe;
  logic [11:0] ad_a0, ad_a1, ad_b0, ad_b1;
  logic        arm1, trig1, abort1, arm4, trig4, abort4;
  logic        out_ready;

  logic        ov1, ol1, busy1, fr1, ov4, ol4, busy4, fr4;
  logic [47:0] od1, od4;
  logic [10:0] fl1, fl4;

  bit          sel;
  logic        ov_s, ol_s, busy_s, fr_s;
  logic [47:0] od_s;
  logic [10:0] fl_s;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fire_capture #(.DEPTH(16), .PRE_TRIG(4), .POST_TRIG(6), .DECIM(1)) dut (
    .clk(clk), .reset(rst), .ad_strobe(ad_strobe),
    .ad_a0(ad_a0), .ad_a1(ad_a1), .ad_b0(ad_b0), .ad_b1(ad_b1),
    .arm(arm1), .trig(trig1), .abort(abort1),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_last(ol1),
    .busy(busy1), .frame_ready(fr1), .frame_len(fl1)
  );

  fire_capture #(.DEPTH(16), .PRE_TRIG(4), .POST_TRIG(6), .DECIM(4)) dut4 (
    .clk(clk), .reset(rst), .ad_strobe(ad_strobe),
    .ad_a0(ad_a0), .ad_a1(ad_a1), .ad_b0(ad_b0), .ad_b1(ad_b1),
    .arm(arm4), .trig(trig4), .abort(abort4),
    .out_valid(ov4), .out_ready(out_ready), .out_data(od4), .out_last(ol4),
    .busy(busy4), .frame_ready(fr4), .frame_len(fl4)
  );

  always_comb begin
    ov_s   = sel ? ov4   : ov1;
    ol_s   = sel ? ol4   : ol1;
    busy_s = sel ? busy4 : busy1;
    fr_s   = sel ? fr4   : fr1;
    od_s   = sel ? od4   : od1;
    fl_s   = sel ? fl4   : fl1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] exp_word(input int v);
    return {12'(v + 300), 12'(v + 200), 12'(v + 100), 12'(v)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int v);
    ad_strobe = 1'b1;
    ad_a0 = 12'(v);
    ad_a1 = 12'(v + 100);
    ad_b0 = 12'(v + 200);
    ad_b1 = 12'(v + 300);
    tick();
    ad_strobe = 1'b0;
  endtask

  task automatic strobes(input int lo, input int hi);
    for (int v = lo; v <= hi; v++) strobe(v);
  endtask

  task automatic pulse_arm();
    if (sel) arm4 = 1'b1; else arm1 = 1'b1;
    tick();
    arm1 = 1'b0; arm4 = 1'b0;
  endtask

  task automatic pulse_trig();
    if (sel) trig4 = 1'b1; else trig1 = 1'b1;
    tick();
    trig1 = 1'b0; trig4 = 1'b0;
  endtask

  // Drains one frame; expected word k carries a0 = first + k*step.
  task automatic read_frame(input string tag, input int n, input int first,
                            input int step, input bit bp);
    int k = 0;
    int cyc = 0;
    int gaps = 0;
    bit started = 0;
    bit held = 0;
    logic [48:0] hv = '0;
    check({tag, "_flen"}, 64'(fl_s), 64'(n));
    while (k < n && cyc < 500) begin
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (held) begin
        check({tag, "_hold"}, 64'({ov_s, ol_s, od_s}), 64'({1'b1, hv}));
        held = 0;
      end
      if (ov_s && out_ready) begin
        check({tag, "_data"}, 64'(od_s), 64'(exp_word(first + k * step)));
        check({tag, "_last"}, 64'(ol_s), 64'(k == n - 1));
        k++;
        started = 1;
      end else begin
        if (ov_s) begin
          held = 1;
          hv = {ol_s, od_s};
        end
        if (started && !bp) gaps++;
      end
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    check({tag, "_count"}, 64'(k), 64'(n));
    if (!bp) check({tag, "_gaps"}, 64'(gaps), 64'd0);
    check({tag, "_busy_after"}, 64'({busy_s, ov_s, fr_s}), 64'd0);
  endtask

  initial begin
    int cyc;
    rst = 1'b1; ad_strobe = 1'b0;
    ad_a0 = '0; ad_a1 = '0; ad_b0 = '0; ad_b1 = '0;
    arm1 = 0; trig1 = 0; abort1 = 0; arm4 = 0; trig4 = 0; abort4 = 0;
    out_ready = 1'b0; sel = 0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset values
    check("rst_valid", 64'(ov1), 64'd0);
    check("rst_last", 64'(ol1), 64'd0);
    check("rst_data", 64'(od1), 64'd0);
    check("rst_busy", 64'(busy1), 64'd0);
    check("rst_fready", 64'(fr1), 64'd0);
    check("rst_flen", 64'(fl1), 64'd0);
    check("rst_busy4", 64'(busy4), 64'd0);

    // trig while idle is ignored
    pulse_trig();
    check("idle_trig", 64'(busy1), 64'd0);

    // Happy path: frame a0 = 7..16
    pulse_arm();
    check("arm_busy", 64'(busy1), 64'd1);
    strobes(1, 10);
    pulse_trig();
    strobes(11, 16);
    check("happy_fready", 64'(fr1), 64'd1);
    strobes(17, 18);
    read_frame("happy", 10, 7, 1, 0);

    // Short pre-window: frame a0 = 1..8
    pulse_arm();
    strobes(1, 2);
    pulse_trig();
    strobes(3, 8);
    check("short_fready", 64'(fr1), 64'd1);
    read_frame("short", 8, 1, 1, 0);

    // Trig coincident with strobe a0=6: frame a0 = 2..11
    pulse_arm();
    strobes(1, 5);
    trig1 = 1'b1;
    strobe(6);
    trig1 = 1'b0;
    strobes(7, 11);
    check("coinc_fready", 64'(fr1), 64'd1);
    strobe(12);
    read_frame("coinc", 10, 2, 1, 0);

    // Ring wrap plus backpressure: frame a0 = 27..36
    pulse_arm();
    strobes(1, 30);
    pulse_trig();
    strobes(31, 36);
    check("wrap_fready", 64'(fr1), 64'd1);
    read_frame("wrap", 10, 27, 1, 1);

    // Abort mid-post, together with a strobe
    pulse_arm();
    strobes(1, 5);
    pulse_trig();
    strobes(6, 8);
    abort1 = 1'b1;
    strobe(9);
    abort1 = 1'b0;
    check("abort_state", 64'({busy1, ov1, ol1, fr1}), 64'd0);
    check("abort_flen", 64'(fl1), 64'd10);
    strobes(10, 14);
    check("abort_stay", 64'({busy1, ov1, fr1}), 64'd0);

    // Reset while streaming is stalled
    pulse_arm();
    strobes(1, 5);
    pulse_trig();
    strobes(6, 11);
    check("rstrd_fready", 64'(fr1), 64'd1);
    cyc = 0;
    while (!ov1 && cyc < 10) begin tick(); cyc++; end
    check("rstrd_valid", 64'(ov1), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstrd_outs", 64'({ov1, ol1, busy1, fr1}), 64'd0);
    check("rstrd_data", 64'(od1), 64'd0);
    check("rstrd_flen", 64'(fl1), 64'd0);

    // DECIM=4: kept a0 = 1,5,9,...; frame a0 = 5,9,...,41
    sel = 1;
    pulse_arm();
    strobes(1, 20);
    pulse_trig();
    strobes(21, 41);
    check("dec_fready", 64'(fr4), 64'd1);
    strobes(42, 44);
    read_frame("dec", 10, 5, 4, 0);

    // DECIM=4 abort mid-post
    pulse_arm();
    strobes(1, 8);
    pulse_trig();
    strobes(9, 16);
    check("dec_inpost", 64'(busy4), 64'd1);
    abort4 = 1'b1;
    tick();
    abort4 = 1'b0;
    check("dec_abort", 64'({busy4, ov4, ol4, fr4}), 64'd0);
    check("dec_abort_flen", 64'(fl4), 64'd10);
    repeat (4) tick();
    check("dec_abort_stay", 64'(ov4), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fire_capture.md
Name: fire_capture

Overview:
- Downstream consumer of the blaster ADC monitor bus (ad_a0/ad_a1/ad_b0/ad_b1 plus ad_strobe).
- Records a pre/post-trigger window of ADC sample sets around a fire event into a circular on-chip RAM.
- After capture, streams the frame out over a valid/ready interface for the host/UART dumper, for post-shot analysis of vcap, icap, vout and iout.

Parameters:
- DEPTH, 1024: RAM entries. Power of two, >= PRE_TRIG + POST_TRIG.
- PRE_TRIG, 128: maximum samples kept from before the trigger.
- POST_TRIG, 768: samples recorded from the trigger onwards.
- DECIM, 4: store one of every DECIM strobes; range 1..255.

Ports:
- clk  in  1  system clock (48 MHz)
- reset  in  1  synchronous, active-high
- ad_strobe  in  1  one-cycle pulse; ad_* buses valid this cycle
- ad_a0  in  12  iout
- ad_a1  in  12  vout
- ad_b0  in  12  icap
- ad_b1  in  12  vcap
- arm  in  1  pulse; start pre-trigger recording
- trig  in  1  pulse; fire event (blaster entered S_FIRE)
- abort  in  1  pulse; discard and return to idle
- out_valid  out  1  stream word valid
- out_ready  in  1  consumer accepts word
- out_data  out  48  {ad_b1, ad_b0, ad_a1, ad_a0}
- out_last  out  1  final word of frame
- busy  out  1  state != S_IDLE
- frame_ready  out  1  high in S_DONE
- frame_len  out  11  entries in captured frame

Behaviour:
- Reset values: out_valid=0, out_last=0, out_data=0, busy=0, frame_ready=0, frame_len=0. Internally: wr_ptr=0, counters=0, state S_IDLE.
- Decimation counter: cleared on arm. A strobe is "kept" when dec_cnt==0. Each strobe sets dec_cnt <= (dec_cnt==DECIM-1) ? 0 : dec_cnt+1. With DECIM=1, every strobe is kept.
- Kept sample: write {b1,b0,a1,a0} at wr_ptr, then wr_ptr <= wr_ptr+1 mod DEPTH (wraps silently).
- States:
  - S_IDLE: no writes. arm -> S_PRE, clearing pre_cnt and dec_cnt. trig is ignored.
  - S_PRE: keeps samples. pre_cnt increments per kept sample, saturating at PRE_TRIG.
    - trig -> S_POST: latch pre_len=pre_cnt, start_ptr=wr_ptr-pre_cnt (mod DEPTH), post_cnt=0.
    - Trig and a kept strobe in the same cycle: that sample is post-trigger sample 0. It is not counted in pre_cnt and start_ptr uses the pre-write wr_ptr.
  - S_POST: keeps samples, post_cnt++. When the kept sample makes post_cnt==POST_TRIG -> S_DONE, with frame_len=pre_len+POST_TRIG.
  - S_DONE: frame_ready=1, no writes, strobes ignored. First cycle where out_ready=1 or out_valid=0 -> S_READ; rd_ptr=start_ptr, rd_cnt=0.
  - S_READ: streams frame_len words from start_ptr upward, mod DEPTH.
- Stream rules:
  - Standard valid/ready. The transfer occurs on clk when out_valid && out_ready.
  - While out_valid && !out_ready, out_data and out_last hold stable.
  - RAM read latency is 1 cycle. The first out_valid is at most 2 cycles after entering S_READ.
  - Full throughput required: one word per cycle while out_ready stays high. Use a prefetch/skid register as needed.
  - out_last=1 only with the word whose rd_cnt==frame_len-1. After that transfer: out_valid=0, next state S_IDLE, frame_ready=0.
- arm outside S_IDLE is ignored. trig outside S_PRE is ignored.
- abort in any state -> S_IDLE next cycle, out_valid=0, out_last=0. Frame is discarded and frame_len is kept. abort has priority over arm, trig and strobe in the same cycle.
- Short pre-window: trig before PRE_TRIG kept samples gives pre_len=pre_cnt, possibly 0. The oldest entry is never past the ring boundary because PRE_TRIG+POST_TRIG <= DEPTH.
- Reset mid-operation: all state lost, outputs return to reset values next cycle.
- Strobes arriving faster than one per cycle cannot occur. Back-to-back strobes (every cycle) must be accepted.

Test Plan:
- Happy path, DECIM=1, PRE_TRIG=4, POST_TRIG=6, DEPTH=16: arm, 10 strobes with a0=1..10, trig, 8 strobes a0=11..18 -> frame_len=10; stream a0 = 7,8,9,10,11..16; out_last on 16; then busy=0.
- Short pre-window: arm, 2 strobes (a0=1,2), trig, 6 strobes -> frame_len=8; stream starts a0=1.
- Trig coincident with a strobe: arm, 5 strobes, trig in the same cycle as strobe a0=6 -> a0=6 is the first post sample; pre words are a0=2..5.
- Wrap-around with DEPTH=16: arm, 30 pre strobes, then trig -> correct ordering across address 15->0; frame_len=10.
- Backpressure: toggle out_ready pseudo-randomly during S_READ -> out_data stable while stalled; no drop or duplicate; exactly frame_len transfers. With out_ready held at 1, one word per cycle.
- DECIM=4 plus abort: 40 strobes store every 4th (a0=1,5,9,...). abort in mid-S_POST -> idle next cycle, out_valid stays 0. Reset during S_READ -> all outputs at reset values next cycle.
